// File: rtl/parity_checker.sv
// parity_checker: serial frame receiver with parity check.
// Deserialises DATA_W data bits (LSB first) followed by one parity bit and
// presents the word with a parity-error flag. All outputs are registered.
// Optional feature macro: PARITY_CHK_ERRCNT_EN adds an 8-bit saturating
// parity-error counter on port err_count.
module parity_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_start,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              parity_err,
    output logic              busy
`ifdef PARITY_CHK_ERRCNT_EN
   ,output logic [7:0]        err_count
`endif
);

    // Counter must be able to hold DATA_W after the last data bit is stored.
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              busy_q, busy_d;

    // Next-state logic: frame_start with bit_valid always (re)starts a frame,
    // which covers both the IDLE start and an abandon/restart mid-frame.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        perr_d  = perr_q;
        done_d  = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                state_d   = DATA;
                sreg_d    = '0;
                sreg_d[0] = bit_in;
                acc_d     = bit_in;
                cnt_d     = CNT_W'(1);
            end else begin
                case (state_q)
                    IDLE: begin
                        // stray bits outside a frame are dropped
                    end
                    DATA: begin
                        // explicit compare loop keeps the index width exact
                        for (int i = 0; i < DATA_W; i++) begin
                            if (cnt_q == CNT_W'(i)) sreg_d[i] = bit_in;
                        end
                        acc_d = acc_q ^ bit_in;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) state_d = PARITY;
                    end
                    PARITY: begin
                        data_d  = sreg_q;
                        perr_d  = acc_q ^ bit_in ^ ODD;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        // busy tracks the registered state so it rises with data bit 0 and
        // falls on the same edge frame_done rises
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign frame_done = done_q;
    assign parity_err = perr_q;
    assign busy       = busy_q;

`ifdef PARITY_CHK_ERRCNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    // Count completed frames with bad parity; updates together with
    // parity_err and sticks at 255.
    always_comb begin
        ecnt_d = ecnt_q;
        if (done_d && perr_d && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) ecnt_q <= 8'd0;
        else     ecnt_q <= ecnt_d;
    end

    assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_parity_checker.sv
// Testbench for parity_checker: an even-parity and an odd-parity instance
// share the same serial stimulus; a scoreboard queue holds the expected word,
// both parity flags and the expected frame_done cycle for each frame.
module tb_parity_checker;

    logic       clk = 1'b0;
    logic       rst, bit_in, bit_valid, frame_start;
    logic [7:0] d0, d1;
    logic       fd0, fd1, pe0, pe1, b0, b1;
`ifdef PARITY_CHK_ERRCNT_EN
    logic [7:0] ec0, ec1;
`endif

    always #5 clk = ~clk;

    parity_checker #(.DATA_W(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(d0), .frame_done(fd0),
        .parity_err(pe0), .busy(b0)
`ifdef PARITY_CHK_ERRCNT_EN
       ,.err_count(ec0)
`endif
    );

    parity_checker #(.DATA_W(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(d1), .frame_done(fd1),
        .parity_err(pe1), .busy(b1)
`ifdef PARITY_CHK_ERRCNT_EN
       ,.err_count(ec1)
`endif
    );

    typedef struct {
        logic [7:0]  d;
        logic        e0;
        logic        e1;
        int unsigned c;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          m0 = 0;
    int          m1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every frame_done must match the oldest pending frame.
    always @(negedge clk) begin
        exp_t e;
        if (fd0 === 1'b1 || fd1 === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {30'd0, fd1, fd0}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_even", fd0, 1);
                chk("done_odd", fd1, 1);
                chk("latency", cyc, e.c);
                chk("data_even", d0, e.d);
                chk("data_odd", d1, e.d);
                chk("perr_even", pe0, e.e0);
                chk("perr_odd", pe1, e.e1);
                if (e.e0 && m0 < 255) m0++;
                if (e.e1 && m1 < 255) m1++;
`ifdef PARITY_CHK_ERRCNT_EN
                chk("errcnt_even", ec0, m0);
                chk("errcnt_odd", ec1, m1);
`endif
            end
        end
    end

    task automatic drive(input logic b, input logic st);
        bit_in      = b;
        bit_valid   = 1'b1;
        frame_start = st;
        @(negedge clk);
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic gap_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("busy_gap_even", b0, 1);
            chk("busy_gap_odd", b1, 1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive(d[i], i == 0);
            gap_cycles(gap);
        end
        e.d  = d;
        e.e0 = (^d) ^ p;
        e.e1 = ~((^d) ^ p);
        e.c  = cyc + 1;
        q.push_back(e);
        drive(p, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, {d1, d0}, 0);
        chk({tag, "_done"}, {fd1, fd0}, 0);
        chk({tag, "_perr"}, {pe1, pe0}, 0);
        chk({tag, "_busy"}, {b1, b0}, 0);
`ifdef PARITY_CHK_ERRCNT_EN
        chk({tag, "_errcnt"}, {ec1, ec0}, 0);
`endif
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // even parity, good and bad
        send_frame(8'hA5, 1'b0, 0);
        chk("busy_fall", {b1, b0}, 0);
        send_frame(8'hA5, 1'b1, 0);

        // sparse bits, busy held through gaps
        send_frame(8'h01, 1'b0, 3);

        // restart after 4 bits; outputs hold meanwhile
        drive(1'b1, 1'b1); drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        chk("held_data", d0, 8'h01);
        chk("held_busy", b0, 1);
        send_frame(8'h3C, 1'b0, 0);

        // restart while waiting for the parity bit
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0);
        send_frame(8'h5A, 1'b0, 0);

        // reset mid-frame, with a start bit presented during reset
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0);
        rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0; frame_start = 1'b0;
        m0 = 0; m1 = 0;
        check_zero("midreset");
        rst = 1'b0;

        // back-to-back frames
        send_frame(8'hFF, 1'b0, 0);
        send_frame(8'h00, 1'b1, 0);

        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom);
            send_frame(r, 1'($urandom_range(0, 1)), 0);
        end

`ifdef PARITY_CHK_ERRCNT_EN
        for (int k = 0; k < 260; k++) begin
            r = 8'($urandom);
            send_frame(r, ~(^r), 0);
        end
        @(negedge clk);
        chk("errcnt_sat", ec0, 255);
`endif

        repeat (5) @(negedge clk);
        chk("no_stray_done", {fd1, fd0}, 0);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
